// File: rtl/bramsd_be.sv
// Semi dual port block RAM with byte-lane writes, read enable/valid,
// 1- or 2-cycle read latency and selectable read-during-write result.
module bramsd_be #(
  parameter int ADDR_  = 8,
  parameter int DATA_  = 32,
  parameter int LANES_ = 4,
  parameter int LAT_   = 2,
  parameter int FWD_   = 0
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              we,
  input  logic [LANES_-1:0] be,
  input  logic [ADDR_-1:0]  waddr,
  input  logic [DATA_-1:0]  din,
  input  logic              re,
  input  logic [ADDR_-1:0]  raddr,
  output logic [DATA_-1:0]  dout,
  output logic              dvalid
);

  localparam int LW    = DATA_ / LANES_;
  localparam int DEPTH = 2 ** ADDR_;

  if (LAT_ != 1 && LAT_ != 2) begin : g_lat_bad
    $error("bramsd_be: LAT_ must be 1 or 2");
  end
  if (DATA_ % LANES_ != 0) begin : g_lane_bad
    $error("bramsd_be: DATA_ must be a multiple of LANES_");
  end

  logic [DATA_-1:0] mem [DEPTH] = '{default: '0};

  // Replace the lanes selected by en with the matching lanes of new_w.
  function automatic logic [DATA_-1:0] lane_merge(input logic [DATA_-1:0]  old_w,
                                                  input logic [DATA_-1:0]  new_w,
                                                  input logic [LANES_-1:0] en);
    logic [DATA_-1:0] res;
    res = old_w;
    for (int i = 0; i < LANES_; i++) begin
      if (en[i]) res[i*LW +: LW] = new_w[i*LW +: LW];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!sclr && we) begin
      for (int i = 0; i < LANES_; i++) begin
        if (be[i]) mem[waddr][i*LW +: LW] <= din[i*LW +: LW];
      end
    end
  end

  // p0 -> p1: RAM read; write-through lanes are merged only in NEW_DATA mode
  logic [LANES_-1:0] fwd_be_p0;
  logic [DATA_-1:0]  dat_p1 = '0;
  logic              vld_p1 = 1'b0;

  assign fwd_be_p0 = (FWD_ != 0 && we && (waddr == raddr)) ? be : '0;

  always_ff @(posedge clk) begin
    if (sclr) begin
      dat_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= re;
      if (re) dat_p1 <= lane_merge(mem[raddr], din, fwd_be_p0);
    end
  end

  if (LAT_ == 1) begin : g_lat1
    assign dout   = dat_p1;
    assign dvalid = vld_p1;
  end else begin : g_lat2
    // p1 -> p2: output register loads only on a valid result so dout holds
    logic [DATA_-1:0] dat_p2 = '0;
    logic             vld_p2 = 1'b0;

    always_ff @(posedge clk) begin
      if (sclr) begin
        dat_p2 <= '0;
        vld_p2 <= 1'b0;
      end else begin
        vld_p2 <= vld_p1;
        if (vld_p1) dat_p2 <= dat_p1;
      end
    end

    assign dout   = dat_p2;
    assign dvalid = vld_p2;
  end

endmodule

// File: tb/tb_bramsd_be.sv
// Scoreboard bench for bramsd_be: a LAT_=2/OLD_DATA and a LAT_=1/NEW_DATA
// instance share one stimulus stream and are checked against a reference memory.
module tb_bramsd_be;

  logic        clk = 1'b0;
  logic        sclr = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  be = '0;
  logic [7:0]  waddr = '0;
  logic [7:0]  raddr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout0, dout1;
  logic        dvalid0, dvalid1;

  always #5 clk = ~clk;

  bramsd_be #(.ADDR_(8), .DATA_(32), .LANES_(4), .LAT_(2), .FWD_(0)) u_l2_old (
    .clk(clk), .sclr(sclr), .we(we), .be(be), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout0), .dvalid(dvalid0));

  bramsd_be #(.ADDR_(8), .DATA_(32), .LANES_(4), .LAT_(1), .FWD_(1)) u_l1_new (
    .clk(clk), .sclr(sclr), .we(we), .be(be), .waddr(waddr), .din(din),
    .re(re), .raddr(raddr), .dout(dout1), .dvalid(dvalid1));

  typedef struct {
    int          iss;
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         q0[$];
  rd_t         q1[$];
  rd_t         mon_it;
  logic [31:0] ref_mem [256];
  logic [31:0] held0 = '0;
  logic [31:0] held1 = '0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        sclr_d = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    sclr_d <= sclr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sclr_d) begin
      while (q0.size() != 0 && q0[0].iss <= cyc) void'(q0.pop_front());
      while (q1.size() != 0 && q1[0].iss <= cyc) void'(q1.pop_front());
      held0 = '0;
      held1 = '0;
    end
    if (dvalid0) begin
      if (q0.size() == 0) chk("l2_dv_spur", 32'(dvalid0), 32'd0);
      else begin
        mon_it = q0.pop_front();
        chk("l2_dv_due", 32'(cyc), 32'(mon_it.due));
        chk("l2_dout", dout0, mon_it.data);
        held0 = mon_it.data;
      end
    end else begin
      if (q0.size() != 0 && q0[0].due <= cyc) begin
        void'(q0.pop_front());
        chk("l2_dv_miss", 32'(dvalid0), 32'd1);
      end
      chk("l2_hold", dout0, held0);
    end
    if (dvalid1) begin
      if (q1.size() == 0) chk("l1_dv_spur", 32'(dvalid1), 32'd0);
      else begin
        mon_it = q1.pop_front();
        chk("l1_dv_due", 32'(cyc), 32'(mon_it.due));
        chk("l1_dout", dout1, mon_it.data);
        held1 = mon_it.data;
      end
    end else begin
      if (q1.size() != 0 && q1[0].due <= cyc) begin
        void'(q1.pop_front());
        chk("l1_dv_miss", 32'(dvalid1), 32'd1);
      end
      chk("l1_hold", dout1, held1);
    end
  end

  // One clock of stimulus; expected read results are queued for both instances.
  task automatic drive(input logic w, input logic [3:0] b, input logic [7:0] wa,
                       input logic [31:0] d, input logic r, input logic [7:0] ra,
                       input logic clr);
    rd_t         it;
    logic [31:0] mask, old_w, new_w;
    @(posedge clk);
    #1;
    we = w; be = b; waddr = wa; din = d; re = r; raddr = ra; sclr = clr;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    if (!clr) begin
      old_w = ref_mem[ra];
      new_w = (w && wa == ra) ? ((old_w & ~mask) | (d & mask)) : old_w;
      if (r) begin
        it.iss = cyc + 1;
        it.due = cyc + 2; it.data = old_w; q0.push_back(it);
        it.due = cyc + 1; it.data = new_w; q1.push_back(it);
      end
      if (w) ref_mem[wa] = (ref_mem[wa] & ~mask) | (d & mask);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // reset with active strobes: nothing written, nothing returned
    drive(1'b1, 4'hF, 8'h20, 32'hDEADBEEF, 1'b1, 8'h20, 1'b1);
    drive(1'b1, 4'hF, 8'h20, 32'hDEADBEEF, 1'b1, 8'h20, 1'b1);
    idle(2);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h20, 1'b0);
    idle(3);

    // byte-lane writes
    drive(1'b1, 4'b1111, 8'h10, 32'hAABBCCDD, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 4'b0101, 8'h10, 32'h11223344, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h10, 1'b0);
    idle(3);

    // pipelined reads
    for (int k = 0; k < 4; k++)
      drive(1'b1, 4'hF, 8'(k), 32'(k) * 32'h01010101, 1'b0, 8'h00, 1'b0);
    idle(1);
    for (int k = 0; k < 4; k++)
      drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'(k), 1'b0);
    idle(4);

    // collision, then re-read
    drive(1'b1, 4'hF, 8'h05, 32'h12345678, 1'b0, 8'h00, 1'b0);
    idle(1);
    drive(1'b1, 4'b0011, 8'h05, 32'hFFFFFFFF, 1'b1, 8'h05, 1'b0);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h05, 1'b0);
    idle(3);

    // reset while a read is in flight
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h03, 1'b0);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b1);
    idle(1);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h02, 1'b0);
    idle(3);

    // address extremes
    drive(1'b1, 4'hF, 8'h00, 32'hA5A50001, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 4'hF, 8'hFF, 32'h5A5A00FF, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 1'b0);
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'hFF, 1'b0);
    idle(3);

    // randomised traffic; narrow addresses half the time to force collisions
    for (int n = 0; n < 10000; n++) begin
      logic [7:0] wa, ra;
      wa = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      drive(1'($urandom), 4'($urandom), wa, $urandom, 1'($urandom), ra,
            $urandom_range(0, 99) == 0);
    end
    idle(5);

    chk("l2_drain", 32'(q0.size()), 32'd0);
    chk("l1_drain", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
